pcs_tx_gearbox: RTL and testbench
=================================

Name: pcs_tx_gearbox

Overview:
- TX gearbox, directly downstream of the TX 64b/66b scrambler.
- Consumes 66-bit blocks: 2-bit sync header plus 64-bit scrambled payload.
- Emits a continuous 64-bit word stream to the PMA/SerDes parallel interface.
- Packs 32 blocks (2112 bits) into 33 output words; stalls the upstream one cycle in every 33 via ready_o.

Parameters:
- HEAD_W, 2, sync header width in bits.
- DATA_W, 64, scrambled payload width; also the output word width.
- SEQ_MAX, 32, input blocks per gearbox period; the period is SEQ_MAX+1 cycles.

Ports:
- clk  input  1  single clock for the whole block.
- nreset  input  1  asynchronous, active-low reset.
- valid_i  input  1  head_i/data_i carry a block.
- head_i  input  2  sync header (2'b01 data, 2'b10 control), transmitted first.
- data_i  input  64  scrambled payload, bit 0 transmitted first after the header.
- ready_o  output  1  block accepted this cycle when valid_i && ready_o.
- valid_o  output  1  data_o holds a valid PMA word.
- data_o  output  64  PMA word, bit 0 transmitted first.
- seq_o  output  6  current sequence count 0..32, for debug and PMA alignment.

Behaviour:
- Block assembly: blk[65:0] = {data_i, head_i}; the header occupies bits [1:0].
- State: seq_q (6b, 0..32) and residual register res_q (64b). The valid residual width is r = 2*seq_q bits, held in res_q[r-1:0]; upper bits are don't-care but must be driven to zero.
- ready_o is combinational from state only: ready_o = (seq_q != 32). It must not depend on valid_i.
- Accept cycle (seq_q = s < 32, valid_i = 1):
  - cat = {blk, res_q[r-1:0]}, width 66+r bits.
  - data_o <= cat[63:0].
  - res_q <= cat[65+r:64], width r+2 bits, zero-extended.
  - seq_q <= s+1; valid_o <= 1.
- Drain cycle (seq_q = 32): data_o <= res_q (exactly 64 bits); res_q <= 0; seq_q <= 0; valid_o <= 1. Input is ignored.
- Underrun (seq_q < 32, valid_i = 0): seq_q and res_q hold; valid_o <= 0; data_o holds its previous value. The stream resumes seamlessly on the next valid block.
- Latency: one cycle from accepted block to data_o/valid_o (registered outputs). The drain word appears in the cycle after seq_q reaches 32.
- Throughput: with valid_i held high, valid_o stays high every cycle; ready_o is low exactly 1 cycle in 33.
- Reset (asynchronous, any time, including mid-period): seq_q=0, res_q=0, valid_o=0, data_o=0, seq_o=0, ready_o=1 after release. A partially packed period is discarded; no residual bits leak into the first word after reset.
- Width rule: the residual mux is indexed by seq_q; r ranges over even values 0..62 on accept cycles and is 64 on the drain cycle. No arithmetic overflow is possible; seq_q never exceeds 32.
- No backpressure from the PMA: the output side is always ready.

Decomposition:
- Shared package pcs_pkg:
  - HEAD_W, DATA_W, BLOCK_W=66.
  - GEARBOX_SEQ_MAX=32.
  - SYNC_DATA=2'b01, SYNC_CTRL=2'b10.
- The package is shared with the scrambler and the future RX gearbox/block-lock.
- No sub-module required. The variable-shift concatenation is a single indexed mux and stays inline.

Test Plan:
1. Reset, then head=2'b01, data=64'h0 at seq 0 -> next cycle data_o=64'h0000_0000_0000_0001, valid_o=1, seq_o=1, res_q=0.
2. head=2'b10, data=64'hFFFF_FFFF_FFFF_FFFF, then head=2'b01, data=0:
   - first word 64'hFFFF_FFFF_FFFF_FFFE;
   - second word 64'h0000_0000_0000_0007.
3. valid_i held high for 66 blocks of alternating patterns -> ready_o low only when seq_o=32 (cycles 33 and 66). valid_o stays high throughout. Concatenated output bitstream equals the concatenated input blocks (scoreboard).
4. valid_i dropped for 3 cycles at seq 17 -> valid_o=0 for those 3 cycles, seq_o stays 17. Bitstream is unbroken after resume.
5. nreset asserted at seq 20, released, then head=2'b01, data=64'h1234_5678_9ABC_DEF0 -> first word 64'h48D1_59E2_6AF3_7BC1, seq_o=1. No stale residual appears.
6. valid_i held high during the drain cycle (seq_o=32) -> block not consumed (ready_o=0). The same block is accepted next cycle at seq 0.

Source files
------------

// File: rtl/pcs_pkg.sv
// Shared 64b/66b PCS constants: block geometry, gearbox period and sync headers.
// Imported by the scrambler, TX gearbox and RX gearbox/block-lock.
package pcs_pkg;
    localparam int HEAD_W          = 2;
    localparam int DATA_W          = 64;
    localparam int BLOCK_W         = HEAD_W + DATA_W;
    localparam int GEARBOX_SEQ_MAX = 32;

    localparam logic [HEAD_W-1:0] SYNC_DATA = 2'b01;
    localparam logic [HEAD_W-1:0] SYNC_CTRL = 2'b10;
endpackage

// File: rtl/pcs_tx_gearbox.sv
// TX gearbox: packs 66-bit blocks into a continuous 64-bit PMA word stream.
// Latency 1 cycle; ready_o drops for the single drain cycle in every SEQ_MAX+1.
module pcs_tx_gearbox
    import pcs_pkg::*;
#(
    parameter  int HEAD_W  = pcs_pkg::HEAD_W,
    parameter  int DATA_W  = pcs_pkg::DATA_W,
    parameter  int SEQ_MAX = pcs_pkg::GEARBOX_SEQ_MAX,
    localparam int SEQ_W   = $clog2(SEQ_MAX + 1)
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              valid_i,
    input  logic [HEAD_W-1:0] head_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [SEQ_W-1:0]  seq_o
);

    localparam int BLK_W = HEAD_W + DATA_W;
    localparam int CAT_W = 2 * DATA_W;
    localparam int SH_W  = $clog2(CAT_W);

    logic [SEQ_W-1:0]  seq_q,   seq_d;
    logic [DATA_W-1:0] res_q,   res_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              valid_q, valid_d;

    logic              drain;
    logic [BLK_W-1:0]  blk;
    logic [SH_W-1:0]   shift;
    logic [CAT_W-1:0]  cat;

    assign drain   = (seq_q == SEQ_W'(SEQ_MAX));
    assign ready_o = !drain;
    assign blk     = {data_i, head_i};

    // The residual occupies res_q[r-1:0] with upper bits kept zero, so the new
    // block is simply shifted up by r and OR-ed over it.
    always_comb begin
        shift = SH_W'(int'(seq_q) * HEAD_W);
        cat   = (CAT_W'(blk) << shift) | CAT_W'(res_q);
    end

    always_comb begin
        seq_d   = seq_q;
        res_d   = res_q;
        data_d  = data_q;
        valid_d = 1'b0;
        if (drain) begin
            data_d  = res_q;
            res_d   = '0;
            seq_d   = '0;
            valid_d = 1'b1;
        end else if (valid_i) begin
            data_d  = cat[DATA_W-1:0];
            res_d   = cat[CAT_W-1:DATA_W];
            seq_d   = seq_q + SEQ_W'(1);
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            seq_q   <= '0;
            res_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            seq_q   <= seq_d;
            res_q   <= res_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign seq_o   = seq_q;

endmodule

// File: tb/tb_pcs_tx_gearbox.sv
// Bench for pcs_tx_gearbox: directed steps with a bit-level scoreboard of the
// serial stream (header then payload, LSB first) against the PMA words.
module tb_pcs_tx_gearbox;
    import pcs_pkg::*;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        valid_i = 1'b0;
    logic [1:0]  head_i = 2'b00;
    logic [63:0] data_i = 64'h0;
    logic        ready_o;
    logic        valid_o;
    logic [63:0] data_o;
    logic [5:0]  seq_o;

    pcs_tx_gearbox dut (
        .clk     (clk),
        .nreset  (nreset),
        .valid_i (valid_i),
        .head_i  (head_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .data_o  (data_o),
        .seq_o   (seq_o)
    );

    always #5 clk = ~clk;

    int   vectors = 0;
    int   miscompares = 0;
    logic bitq[$];
    int   mseq = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_word(output logic [63:0] w);
        for (int i = 0; i < 64; i++) begin
            if (bitq.size() > 0) w[i] = bitq.pop_front();
            else                 w[i] = 1'bx;
        end
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input logic v, input logic [1:0] h, input logic [63:0] d);
        logic        acc, drn;
        logic [63:0] w, prev;
        valid_i = v;
        head_i  = h;
        data_i  = d;
        #1;
        chk("ready", {63'h0, ready_o}, {63'h0, mseq != 32});
        drn  = (mseq == 32);
        acc  = v && !drn;
        prev = data_o;
        @(posedge clk);
        #1;
        if (acc) begin
            for (int i = 0; i < 2; i++)  bitq.push_back(h[i]);
            for (int i = 0; i < 64; i++) bitq.push_back(d[i]);
            mseq++;
        end else if (drn) begin
            mseq = 0;
        end
        chk("valid", {63'h0, valid_o}, {63'h0, acc || drn});
        chk("seq", {58'h0, seq_o}, 64'(mseq));
        if (acc || drn) begin
            pop_word(w);
            chk("word", data_o, w);
        end else begin
            chk("hold", data_o, prev);
        end
        @(negedge clk);
    endtask

    task automatic rand_step();
        step(1'b1, ($urandom_range(0, 1) != 0) ? SYNC_DATA : SYNC_CTRL, {$urandom, $urandom});
    endtask

    task automatic run_to(input int target);
        int n = 0;
        while (mseq != target && n < 100) begin
            rand_step();
            n++;
        end
        chk("run_to", {58'h0, seq_o}, 64'(target));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, {63'h0, valid_o}, 64'h0);
        chk({tag, "_data"}, data_o, 64'h0);
        chk({tag, "_seq"}, {58'h0, seq_o}, 64'h0);
        chk({tag, "_ready"}, {63'h0, ready_o}, 64'h1);
        chk({tag, "_res"}, dut.res_q, 64'h0);
    endtask

    // Asynchronous reset asserted mid-cycle, released on a falling edge.
    task automatic reset_mid();
        valid_i = 1'b0;
        #2 nreset = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        @(negedge clk);
        nreset = 1'b1;
        bitq.delete();
        mseq = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int          lowcnt;
        logic [63:0] blk_b;

        // Test 1: reset state, then a single data block
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("rst_init");
        nreset = 1'b1;
        @(negedge clk);
        step(1'b1, SYNC_DATA, 64'h0);
        chk("t1_word", data_o, 64'h0000_0000_0000_0001);
        chk("t1_seq", {58'h0, seq_o}, 64'd1);
        chk("t1_res", dut.res_q, 64'h0);

        // Test 2: header bits carried across the word boundary
        reset_mid();
        step(1'b1, SYNC_CTRL, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t2_word0", data_o, 64'hFFFF_FFFF_FFFF_FFFE);
        step(1'b1, SYNC_DATA, 64'h0);
        chk("t2_word1", data_o, 64'h0000_0000_0000_0007);

        // Test 3: 66 back-to-back cycles, two drains
        reset_mid();
        lowcnt = 0;
        for (int i = 0; i < 66; i++) begin
            if (!ready_o) lowcnt++;
            step(1'b1, i[1] ? SYNC_CTRL : SYNC_DATA,
                 i[0] ? 64'hAAAA_AAAA_AAAA_AAAA : 64'h5555_5555_5555_5555);
        end
        chk("t3_ready_low_cycles", 64'(lowcnt), 64'd2);
        run_to(32);
        step(1'b1, SYNC_DATA, 64'h0);

        // Test 4: underrun at seq 17
        run_to(17);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, SYNC_DATA, {$urandom, $urandom});
            chk("t4_seq_hold", {58'h0, seq_o}, 64'd17);
        end
        run_to(32);
        step(1'b1, SYNC_CTRL, 64'h0);

        // Test 5: reset at seq 20 discards the partial period
        run_to(20);
        reset_mid();
        step(1'b1, SYNC_DATA, 64'h1234_5678_9ABC_DEF0);
        chk("t5_word", data_o, 64'h48D1_59E2_6AF3_7BC1);
        chk("t5_seq", {58'h0, seq_o}, 64'd1);

        // Test 6: block offered during drain is held and accepted at seq 0
        run_to(32);
        blk_b = 64'hDEAD_BEEF_0BAD_F00D;
        step(1'b1, SYNC_CTRL, blk_b);
        chk("t6_seq_after_drain", {58'h0, seq_o}, 64'd0);
        step(1'b1, SYNC_CTRL, blk_b);
        chk("t6_word", data_o, {blk_b[61:0], 2'b10});
        run_to(32);
        step(1'b0, SYNC_DATA, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
